// File: rtl/bus_pkg.sv
// Shared types and address map for the 8088 bus wait-state generator.
package bus_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DECODE = 2'd1,
      WAIT   = 2'd2,
      HOLD   = 2'd3
   } bus_state_t;

   localparam int NUM_CS = 4;
   localparam int WS_W   = 4;

   localparam int CS_MEM0 = 0;
   localparam int CS_MEM1 = 1;
   localparam int CS_IO0  = 2;
   localparam int CS_IO1  = 3;

   localparam logic [19:0] MEM0_LSB = 20'h00000;
   localparam logic [19:0] MEM0_MSB = 20'h7FFFF;
   localparam logic [19:0] MEM1_LSB = 20'h80000;
   localparam logic [19:0] MEM1_MSB = 20'hFFFFF;
   localparam logic [15:0] IO0_LSB  = 16'hFF00;
   localparam logic [15:0] IO0_MSB  = 16'hFF0F;
   localparam logic [15:0] IO1_LSB  = 16'h1C00;
   localparam logic [15:0] IO1_MSB  = 16'h1DFF;

   typedef struct packed {
      logic [NUM_CS-1:0] cs;
      logic [WS_W-1:0]   ws;
   } region_t;

   function automatic logic in_range(input logic [19:0] a,
                                     input logic [19:0] lo,
                                     input logic [19:0] hi);
      return (a >= lo) && (a <= hi);
   endfunction

endpackage

// File: rtl/region_decode.sv
// Combinational address-map lookup: one-hot region select and its wait-state count.
module region_decode
   import bus_pkg::*;
#(
   parameter int unsigned MEM0_WS = 0,
   parameter int unsigned MEM1_WS = 2,
   parameter int unsigned IO0_WS  = 1,
   parameter int unsigned IO1_WS  = 3
) (
   input  logic        iom,
   input  logic [19:0] addr,
   output region_t     region
);

   logic [19:0] io_addr;

   // I/O space is only 16 bits wide; upper address lines are don't-care.
   assign io_addr = {4'h0, addr[15:0]};

   always_comb begin
      region = '0;
      if (iom) begin
         if (in_range(io_addr, {4'h0, IO0_LSB}, {4'h0, IO0_MSB})) begin
            region.cs[CS_IO0] = 1'b1;
            region.ws         = WS_W'(IO0_WS);
         end else if (in_range(io_addr, {4'h0, IO1_LSB}, {4'h0, IO1_MSB})) begin
            region.cs[CS_IO1] = 1'b1;
            region.ws         = WS_W'(IO1_WS);
         end
      end else begin
         if (in_range(addr, MEM0_LSB, MEM0_MSB)) begin
            region.cs[CS_MEM0] = 1'b1;
            region.ws          = WS_W'(MEM0_WS);
         end else if (in_range(addr, MEM1_LSB, MEM1_MSB)) begin
            region.cs[CS_MEM1] = 1'b1;
            region.ws          = WS_W'(MEM1_WS);
         end
      end
   end

endmodule

// File: rtl/bus_wait_gen.sv
// 8088 READY/chip-select generator: decodes each bus cycle and inserts per-region wait states.
module bus_wait_gen
   import bus_pkg::*;
#(
   parameter int unsigned MEM0_WS = 0,
   parameter int unsigned MEM1_WS = 2,
   parameter int unsigned IO0_WS  = 1,
   parameter int unsigned IO1_WS  = 3
) (
   input  logic              CLK,
   input  logic              RESET_N,
   input  logic              ALE,
   input  logic              IOM,
   input  logic [19:0]       Address,
   input  logic              RD,
   input  logic              WR,
   output logic              READY,
   output logic [NUM_CS-1:0] cs,
   output logic              BUSERR
);

   bus_state_t      state;
   logic [WS_W-1:0] counter;
   logic            iom_q;
   logic            dec_done;
   logic            strobe;
   region_t         region;

   assign strobe = ~RD | ~WR;

   region_decode #(
      .MEM0_WS (MEM0_WS),
      .MEM1_WS (MEM1_WS),
      .IO0_WS  (IO0_WS),
      .IO1_WS  (IO1_WS)
   ) u_region_decode (
      .iom    (iom_q),
      .addr   (Address),
      .region (region)
   );

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state    <= IDLE;
         READY    <= 1'b1;
         cs       <= '0;
         BUSERR   <= 1'b0;
         counter  <= '0;
         iom_q    <= 1'b0;
         dec_done <= 1'b0;
      end else begin
         BUSERR <= 1'b0;
         // ALE starts a new cycle from IDLE and aborts any cycle in progress.
         if (ALE) begin
            state    <= DECODE;
            iom_q    <= IOM;
            dec_done <= 1'b0;
            cs       <= '0;
            READY    <= 1'b1;
            counter  <= '0;
         end else begin
            case (state)
               IDLE: begin
               end
               DECODE: begin
                  if (!dec_done) begin
                     cs       <= region.cs;
                     counter  <= region.ws;
                     dec_done <= 1'b1;
                  end else if (strobe) begin
                     if (counter != '0) begin
                        state <= WAIT;
                        READY <= 1'b0;
                     end else begin
                        state  <= HOLD;
                        BUSERR <= (cs == '0);
                     end
                  end
               end
               WAIT: begin
                  if (!strobe) begin
                     state   <= IDLE;
                     READY   <= 1'b1;
                     cs      <= '0;
                     counter <= '0;
                  end else if (counter <= WS_W'(1)) begin
                     // Final wait cycle: counter bottoms out at zero, never wraps.
                     state   <= HOLD;
                     READY   <= 1'b1;
                     counter <= '0;
                  end else begin
                     counter <= counter - WS_W'(1);
                  end
               end
               HOLD: begin
                  if (!strobe) begin
                     state <= IDLE;
                     cs    <= '0;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule
